// File: rtl/axi_lite_write_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite write port (AW/W/B) between NUM_REQ requesters.
// One complete write per grant, with an optional B-channel timeout.
module axi_lite_write_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          done_valid,
    output logic                        done_err,
    output logic                        done_timeout,
    output logic                        busy,
    output logic [ADDR_W-1:0]           aw_addr,
    output logic                        aw_valid,
    input  logic                        aw_ready,
    output logic [DATA_W-1:0]           w_data,
    output logic                        w_valid,
    input  logic                        w_ready,
    input  logic                        b_response,
    input  logic                        b_valid,
    output logic                        b_ready
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {StIdle, StXfer, StResp} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                aw_valid_q, aw_valid_d;
    logic                w_valid_q, w_valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  done_valid_q, done_valid_d;
    logic                done_err_q, done_err_d;
    logic                done_timeout_q, done_timeout_d;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;
    logic                accept;
    logic [IDX_W-1:0]    rr_next;

    // First requesting index scanning upward from rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!pick_found && req_valid[(int'(rr_ptr_q) + k) % int'(NUM_REQ)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
            end
        end
    end

    assign accept    = (state_q == StIdle) && pick_found && !rst;
    assign req_ready = accept ? (ONE_HOT0 << pick_idx) : '0;
    assign rr_next   = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        gnt_d          = gnt_q;
        addr_d         = addr_q;
        data_d         = data_q;
        aw_valid_d     = aw_valid_q;
        w_valid_d      = w_valid_q;
        cnt_d          = cnt_q;
        done_valid_d   = '0;
        done_err_d     = 1'b0;
        done_timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    gnt_d      = pick_idx;
                    addr_d     = req_addr[int'(pick_idx) * ADDR_W +: ADDR_W];
                    data_d     = req_data[int'(pick_idx) * DATA_W +: DATA_W];
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    state_d    = StXfer;
                end
            end
            StXfer: begin
                if (aw_valid_q && aw_ready) aw_valid_d = 1'b0;
                if (w_valid_q && w_ready) w_valid_d = 1'b0;
                // Each channel is finished once its valid has dropped or handshakes now.
                if ((!aw_valid_q || aw_ready) && (!w_valid_q || w_ready)) begin
                    state_d = StResp;
                    cnt_d   = '0;
                end
            end
            StResp: begin
                if (b_valid) begin
                    state_d      = StIdle;
                    rr_ptr_d     = rr_next;
                    done_valid_d = ONE_HOT0 << gnt_q;
                    done_err_d   = b_response;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d        = StIdle;
                    rr_ptr_d       = rr_next;
                    done_valid_d   = ONE_HOT0 << gnt_q;
                    done_err_d     = 1'b1;
                    done_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            rr_ptr_q       <= '0;
            gnt_q          <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            aw_valid_q     <= 1'b0;
            w_valid_q      <= 1'b0;
            cnt_q          <= '0;
            done_valid_q   <= '0;
            done_err_q     <= 1'b0;
            done_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            gnt_q          <= gnt_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            aw_valid_q     <= aw_valid_d;
            w_valid_q      <= w_valid_d;
            cnt_q          <= cnt_d;
            done_valid_q   <= done_valid_d;
            done_err_q     <= done_err_d;
            done_timeout_q <= done_timeout_d;
        end
    end

    assign aw_addr      = addr_q;
    assign aw_valid     = aw_valid_q;
    assign w_data       = data_q;
    assign w_valid      = w_valid_q;
    assign b_ready      = (state_q == StResp);
    assign busy         = (state_q != StIdle);
    assign done_valid   = done_valid_q;
    assign done_err     = done_err_q;
    assign done_timeout = done_timeout_q;

endmodule
